digit_scan_ctrl: RTL and testbench

//  Parametrised multiplexed-display scan controller; successor to the fixed 5-digit scan FSM.

---
 rtl/scan_pkg.sv | 7 +
 rtl/digit_next_sel.sv | 26 ++
 rtl/digit_scan_ctrl.sv | 85 ++++++++
 tb/tb_digit_scan_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and scan-origin helper for the digit scan controller
package scan_pkg;
  typedef enum logic [1:0] {SHOW, GAP, IDLE} scan_state_t;
  function automatic int start_idx(input bit down, input int n);
    return down ? n - 1 : 0;
  endfunction
endpackage

// File: rtl/digit_next_sel.sv
// digit_next_sel: next enabled position strictly after cur in scan direction, with wrap flag
module digit_next_sel #(
  parameter int N        = 5,
  parameter int SEL_W    = $clog2(N),
  parameter int DIR_DOWN = 1
) (
  input  logic [SEL_W-1:0] cur,
  input  logic [N-1:0]     digit_en,
  output logic [SEL_W-1:0] nxt,
  output logic             wrapped,
  output logic             found
);
  int idx;
  // Walk offsets from farthest to nearest so the nearest enabled position wins
  always_comb begin
    nxt = cur;
    idx = 0;
    found = |digit_en;
    for (int k = N; k >= 1; k--) begin
      idx = (DIR_DOWN != 0) ? ((int'(cur) >= k) ? int'(cur) - k : int'(cur) + N - k)
                            : ((int'(cur) + k >= N) ? int'(cur) + k - N : int'(cur) + k);
      if (digit_en[idx[SEL_W-1:0]]) nxt = idx[SEL_W-1:0];
    end
    wrapped = (DIR_DOWN != 0) ? (nxt >= cur) : (nxt <= cur);
  end
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed display scan FSM with dwell, anti-ghost gap and digit masking
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int SEL_W      = $clog2(NUM_DIGITS),
  parameter int DWELL      = 1,
  parameter int BLANK      = 0,
  parameter int DIR_DOWN   = 1
) (
  input  logic                  clk_1ms,
  input  logic                  reset,
  input  logic                  tick_en,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [SEL_W-1:0]      digit_select,
  output logic [NUM_DIGITS-1:0] digit_onehot,
  output logic                  blank,
  output logic                  frame_start
);
  localparam int DW    = $clog2(DWELL + 1);
  localparam int GW    = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam int START = start_idx(DIR_DOWN != 0, NUM_DIGITS);
  localparam int FAR   = start_idx(DIR_DOWN == 0, NUM_DIGITS);
  scan_state_t state, state_n;
  logic [DW-1:0] dwell_cnt, dwell_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [SEL_W-1:0] sel_n, search_cur, nxt;
  logic fs_n, blank_n, adv, wrapped, found;
  // Searching from the far end makes IDLE exit land on the first enabled digit at/after START
  assign search_cur = (state == IDLE) ? SEL_W'(FAR) : digit_select;
  digit_next_sel #(.N(NUM_DIGITS), .SEL_W(SEL_W), .DIR_DOWN(DIR_DOWN)) u_next (
    .cur(search_cur), .digit_en(digit_en), .nxt(nxt), .wrapped(wrapped), .found(found)
  );
  always_comb begin
    state_n = state;
    sel_n = digit_select;
    dwell_n = dwell_cnt;
    gap_n = gap_cnt;
    fs_n = 1'b0;
    adv = 1'b0;
    if (!found) begin
      state_n = IDLE;
      dwell_n = '0;
      gap_n = '0;
    end else if (tick_en) begin
      if (state == IDLE) adv = 1'b1;
      else if (state == SHOW) begin
        if (!digit_en[digit_select] || dwell_cnt == DW'(DWELL - 1)) begin
          dwell_n = '0;
          if (digit_en[digit_select] && BLANK > 0) state_n = GAP;
          else adv = 1'b1;
        end else dwell_n = dwell_cnt + DW'(1);
      end else begin
        if (gap_cnt == GW'(BLANK - 1)) begin
          gap_n = '0;
          adv = 1'b1;
        end else gap_n = gap_cnt + GW'(1);
      end
    end
    if (adv) begin
      sel_n = nxt;
      fs_n = wrapped;
      state_n = SHOW;
    end
    blank_n = (state_n != SHOW) || !digit_en[sel_n];
  end
  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      state <= SHOW;
      digit_select <= SEL_W'(START);
      dwell_cnt <= '0;
      gap_cnt <= '0;
      frame_start <= 1'b0;
      blank <= !digit_en[SEL_W'(START)];
    end else begin
      state <= state_n;
      digit_select <= sel_n;
      dwell_cnt <= dwell_n;
      gap_cnt <= gap_n;
      frame_start <= fs_n;
      blank <= blank_n;
    end
  end
  assign digit_onehot = blank ? '0 : NUM_DIGITS'(1) << digit_select;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: three scan configurations checked every cycle against a tick-counting model
module tb_digit_scan_ctrl;
  localparam int DWP [3] = '{1, 3, 4};
  localparam int BLP [3] = '{0, 2, 1};
  localparam int DNP [3] = '{1, 1, 0};
  logic clk_1ms = 0, reset = 1, tick_en = 0;
  logic [4:0] digit_en = 5'h1F;
  logic [2:0] sel [3];
  logic [4:0] oh [3];
  logic bl [3], fs [3];
  int vectors = 0, miscompares = 0;
  int m_pos [3], m_cnt [3];
  bit m_idle [3], m_gap [3], m_fs [3], m_blank [3];

  always #5 clk_1ms = ~clk_1ms;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    digit_scan_ctrl #(.NUM_DIGITS(5), .DWELL(DWP[g]), .BLANK(BLP[g]), .DIR_DOWN(DNP[g])) dut (
      .clk_1ms(clk_1ms), .reset(reset), .tick_en(tick_en), .digit_en(digit_en),
      .digit_select(sel[g]), .digit_onehot(oh[g]), .blank(bl[g]), .frame_start(fs[g])
    );
  end

  task automatic chk(input string tag, input int i, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s inst%0d got %0h exp %0h", tag, i, got, exp);
    end
  endtask

  // Move to the nearest enabled digit k steps away; crossing the array end marks a new frame
  task automatic advance(input int i, input logic [4:0] m);
    bit done = 0;
    for (int k = 1; k <= 5; k++) begin
      int p = DNP[i] ? m_pos[i] - k : m_pos[i] + k;
      bit w = (p < 0) || (p >= 5);
      p = (p + 5) % 5;
      if (!done && m[p]) begin
        m_pos[i] = p;
        m_fs[i] = w;
        done = 1;
      end
    end
    m_cnt[i] = 0;
    m_gap[i] = 0;
  endtask

  task automatic model(input logic r, input logic t, input logic [4:0] m);
    for (int i = 0; i < 3; i++) begin
      m_fs[i] = 0;
      if (r) begin
        m_idle[i] = 0; m_gap[i] = 0; m_cnt[i] = 0;
        m_pos[i] = DNP[i] ? 4 : 0;
      end else if (m == 0) begin
        m_idle[i] = 1; m_gap[i] = 0; m_cnt[i] = 0;
      end else if (t) begin
        if (m_idle[i]) begin
          bit done = 0;
          for (int k = 0; k < 5; k++) begin
            int p = DNP[i] ? 4 - k : k;
            if (!done && m[p]) begin m_pos[i] = p; done = 1; end
          end
          m_idle[i] = 0; m_cnt[i] = 0; m_fs[i] = 1;
        end else if (!m_gap[i] && !m[m_pos[i]]) advance(i, m);
        else if (!m_gap[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DWP[i]) begin
            m_cnt[i] = 0;
            if (BLP[i] > 0) m_gap[i] = 1;
            else advance(i, m);
          end
        end else begin
          m_cnt[i]++;
          if (m_cnt[i] == BLP[i]) advance(i, m);
        end
      end
      m_blank[i] = m_idle[i] || m_gap[i] || !m[m_pos[i]];
    end
  endtask

  task automatic step(input logic r, input logic t, input logic [4:0] m);
    reset = r; tick_en = t; digit_en = m;
    @(posedge clk_1ms);
    model(r, t, m);
    @(negedge clk_1ms);
    for (int i = 0; i < 3; i++) begin
      chk("select", i, int'(sel[i]), m_pos[i]);
      chk("blank", i, int'(bl[i]), int'(m_blank[i]));
      chk("onehot", i, int'(oh[i]), m_blank[i] ? 0 : (1 << m_pos[i]));
      chk("frame_start", i, int'(fs[i]), int'(m_fs[i]));
    end
  endtask

  initial begin
    logic [4:0] msk = 5'h1F;
    step(1, 1, 5'h1F);
    step(1, 0, 5'h1F);
    chk("rst_sel_down", 0, int'(sel[0]), 4);
    chk("rst_sel_up", 2, int'(sel[2]), 0);
    chk("rst_fs", 1, int'(fs[1]), 0);
    for (int n = 0; n < 12; n++) step(0, 1, 5'h1F);
    for (int n = 0; n < 30; n++) step(0, 1, 5'h1F);
    for (int n = 0; n < 15; n++) step(0, 1, 5'b10101);
    for (int n = 0; n < 10; n++) step(0, 1, 5'b00100);
    chk("single_sel", 0, int'(sel[0]), 2);
    for (int n = 0; n < 3; n++) step(0, n == 1, 5'b00000);
    chk("idle_onehot", 1, int'(oh[1]), 0);
    step(0, 1, 5'h1F);
    chk("idle_exit_sel", 0, int'(sel[0]), 4);
    chk("idle_exit_fs", 0, int'(fs[0]), 1);
    for (int n = 0; n < 10; n++) step(0, 0, 5'h1F);
    step(1, 0, 5'h1F);
    for (int n = 0; n < 3; n++) step(0, 1, 5'h1F);
    step(1, 1, 5'h1F);
    step(1, 0, 5'h1F);
    step(0, 0, 5'h1F);
    chk("rst_gap_sel", 1, int'(sel[1]), 4);
    chk("rst_gap_blank", 1, int'(bl[1]), 0);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        int r = $urandom_range(0, 99);
        msk = (r < 50) ? 5'h1F : (r < 93) ? 5'($urandom) : 5'h00;
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, msk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
